// File: rtl/irq_priority_unit.sv
// Request side of the 8259 PIC: IR capture into IRR, ISR tracking, fixed or rotating
// priority resolution, the INTA acknowledge sequence, EOI/AEOI handling and read-back.
module irq_priority_unit #(
    parameter int unsigned NUM_IR = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_IR-1:0] IR,
    input  logic              LEVEL,
    input  logic [NUM_IR-1:0] interrupt_mask,
    input  logic              R,
    input  logic              AEOI,
    input  logic              EOI_CMD,
    input  logic [1:0]        INTA_COUNT,
    input  logic              RIRR,
    input  logic              RISR,
    output logic              INTERNAL_INT,
    output logic [2:0]        IR_NUM,
    output logic [NUM_IR-1:0] IRR,
    output logic [NUM_IR-1:0] ISR,
    output logic [NUM_IR-1:0] READ_DATA
);

    localparam int unsigned IDX_W = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_ACK1 = 2'd2;

    logic [1:0]        state, state_n;
    logic [NUM_IR-1:0] s1, s2, s2_d;
    logic [1:0]        inta_prev;
    logic [IDX_W-1:0]  pri_base, pri_base_n;
    logic              spurious, spurious_n;
    logic              int_n;
    logic [IDX_W-1:0]  ir_num_n;
    logic [NUM_IR-1:0] irr_n, isr_n;
    logic [NUM_IR-1:0] irr_set, irr_clr, isr_set, isr_clr;

    logic [NUM_IR-1:0] cand;
    logic [IDX_W:0]    cand_hit, isr_hit;
    logic              cand_any, isr_any, win_valid;
    logic [IDX_W-1:0]  cand_off, isr_off, winner, isr_top;
    logic              ack1, ack2;

    // Offset (relative to base) of the first set bit in rotated search order, plus a found flag.
    function automatic logic [IDX_W:0] first_set(input logic [NUM_IR-1:0] vec,
                                                 input logic [IDX_W-1:0]  base);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] idx;
        res = '0;
        for (int j = NUM_IR - 1; j >= 0; j--) begin
            idx = base + IDX_W'(j);
            if (vec[idx]) begin
                res = {1'b1, IDX_W'(j)};
            end
        end
        return res;
    endfunction

    assign cand      = IRR & ~interrupt_mask;
    assign cand_hit  = first_set(cand, pri_base);
    assign isr_hit   = first_set(ISR, pri_base);
    assign cand_any  = cand_hit[IDX_W];
    assign cand_off  = cand_hit[IDX_W-1:0];
    assign isr_any   = isr_hit[IDX_W];
    assign isr_off   = isr_hit[IDX_W-1:0];
    assign winner    = pri_base + cand_off;
    assign isr_top   = pri_base + isr_off;
    assign win_valid = cand_any && (!isr_any || (cand_off < isr_off));

    // An acknowledge is a transition into 01 or 10; holding the value does not repeat it.
    assign ack1 = (INTA_COUNT == 2'b01) && (inta_prev != 2'b01);
    assign ack2 = (INTA_COUNT == 2'b10) && (inta_prev != 2'b10);

    assign READ_DATA = RISR ? ISR : (RIRR ? IRR : '0);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1        <= '0;
            s2        <= '0;
            s2_d      <= '0;
            inta_prev <= 2'b00;
        end else begin
            s1        <= IR;
            s2        <= s1;
            s2_d      <= s2;
            inta_prev <= INTA_COUNT;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= ST_IDLE;
            INTERNAL_INT <= 1'b0;
            IR_NUM       <= '0;
            IRR          <= '0;
            ISR          <= '0;
            pri_base     <= '0;
            spurious     <= 1'b0;
        end else begin
            state        <= state_n;
            INTERNAL_INT <= int_n;
            IR_NUM       <= ir_num_n;
            IRR          <= irr_n;
            ISR          <= isr_n;
            pri_base     <= pri_base_n;
            spurious     <= spurious_n;
        end
    end

    // EOI acts on the pre-acknowledge ISR; an AEOI rotation overrides the EOI rotation.
    always_comb begin
        state_n    = state;
        int_n      = INTERNAL_INT;
        ir_num_n   = IR_NUM;
        spurious_n = spurious;
        pri_base_n = pri_base;
        irr_set    = LEVEL ? '0 : (s2 & ~s2_d);
        irr_clr    = '0;
        isr_set    = '0;
        isr_clr    = '0;

        if (EOI_CMD && isr_any) begin
            isr_clr[isr_top] = 1'b1;
            if (R) begin
                pri_base_n = isr_top + IDX_W'(1);
            end
        end

        case (state)
            ST_IDLE: begin
                if (win_valid) begin
                    int_n   = 1'b1;
                    state_n = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack1) begin
                    if (win_valid) begin
                        ir_num_n         = winner;
                        spurious_n       = 1'b0;
                        isr_set[winner]  = 1'b1;
                        irr_clr[winner]  = 1'b1;
                    end else begin
                        ir_num_n   = IDX_W'(7);
                        spurious_n = 1'b1;
                    end
                    state_n = ST_ACK1;
                end
            end
            ST_ACK1: begin
                if (ack2) begin
                    int_n = 1'b0;
                    if (AEOI && !spurious) begin
                        isr_clr[IR_NUM] = 1'b1;
                        if (R) begin
                            pri_base_n = IR_NUM + IDX_W'(1);
                        end
                    end
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        irr_n = LEVEL ? s2 : ((IRR & ~irr_clr) | irr_set);
        isr_n = (ISR & ~isr_clr) | isr_set;
    end

endmodule
